// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared constants and types for the LED fade/PWM output stage.
//   LED_N            : number of LED channels on the board
//   CLK_HZ           : system clock frequency
//   LED_ON / LED_OFF : pin levels for the active-low LEDs
//   *_DEF            : default fade/PWM parameters (1 ms steps at 27 MHz)
//   ramp_dir_e       : per-channel ramp direction decoded from level vs target
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int   LED_N    = 6;
    localparam int   CLK_HZ   = 27_000_000;
    localparam logic LED_ON   = 1'b0;
    localparam logic LED_OFF  = 1'b1;

    localparam int PWM_BITS_DEF  = 8;
    localparam int STEP_DIV_DEF  = 27_000;
    localparam int UP_STEP_DEF   = 8;
    localparam int DOWN_STEP_DEF = 2;

    typedef enum logic [1:0] {
        RAMP_HOLD = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_dir_e;

endpackage

// File: rtl/led_fade_pwm_if.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_if
// Bundles the pattern input and LED/busy outputs of the fade stage.
//   pattern_i : target pattern, active-low (0 = lit)
//   led       : LED pins, active-low
//   busy      : some channel has not yet reached its target
// Modports: master = pattern source / pin consumer, slave = fade stage.
// ---------------------------------------------------------------------------
interface led_fade_pwm_if
    import led_pkg::*;
#(
    parameter int N_LED = LED_N
) ();

    logic [N_LED-1:0] pattern_i;
    logic [N_LED-1:0] led;
    logic             busy;

    modport master (
        output pattern_i,
        input  led,
        input  busy
    );

    modport slave (
        input  pattern_i,
        output led,
        output busy
    );

endinterface

// File: rtl/led_fade_chan.sv
// ---------------------------------------------------------------------------
// led_fade_chan
// One LED channel: brightness level register with saturating ramp toward
// the target (full on / full off) and registered PWM compare.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   step_tick        : level may change in this cycle
//   pat_bit          : registered pattern bit, active-low (0 = lit)
//   pwm_cnt          : shared PWM counter, 0..FS-1
//   led_bit          : registered LED pin, active-low
//   ch_busy          : level after this cycle's update differs from target
// ---------------------------------------------------------------------------
module led_fade_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int UP_STEP   = UP_STEP_DEF,
    parameter int DOWN_STEP = DOWN_STEP_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                step_tick,
    input  logic                pat_bit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_bit,
    output logic                ch_busy
);

    // Ramp arithmetic is one bit wider than the level so overflow is visible.
    localparam logic [PWM_BITS:0]   FS_W = (PWM_BITS+1)'((2**PWM_BITS) - 1);
    localparam logic [PWM_BITS:0]   UP_W = (PWM_BITS+1)'(UP_STEP);
    localparam logic [PWM_BITS:0]   DN_W = (PWM_BITS+1)'(DOWN_STEP);
    localparam logic [PWM_BITS-1:0] DN_N = PWM_BITS'(DOWN_STEP);

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [PWM_BITS-1:0] tgt_s;
    logic [PWM_BITS:0]   level_ext_s;
    logic [PWM_BITS:0]   up_sum_s;
    logic                led_q;
    logic                led_d;
    ramp_dir_e           dir_s;

    // Target, ramp direction, saturating next level and PWM compare.
    always_comb begin
        tgt_s       = pat_bit ? {PWM_BITS{1'b0}} : {PWM_BITS{1'b1}};
        level_ext_s = {1'b0, level_q};
        up_sum_s    = level_ext_s + UP_W;
        level_d     = level_q;
        dir_s       = RAMP_HOLD;

        if (level_q < tgt_s) begin
            dir_s = RAMP_UP;
        end else if (level_q > tgt_s) begin
            dir_s = RAMP_DOWN;
        end else begin
            dir_s = RAMP_HOLD;
        end

        if (step_tick) begin
            case (dir_s)
                RAMP_UP: begin
                    if (up_sum_s > FS_W) begin
                        level_d = FS_W[PWM_BITS-1:0];
                    end else begin
                        level_d = up_sum_s[PWM_BITS-1:0];
                    end
                end
                RAMP_DOWN: begin
                    // Clamp at zero instead of wrapping through full scale.
                    if (level_ext_s < DN_W) begin
                        level_d = {PWM_BITS{1'b0}};
                    end else begin
                        level_d = level_q - DN_N;
                    end
                end
                default: begin
                    level_d = level_q;
                end
            endcase
        end else begin
            level_d = level_q;
        end

        ch_busy = (level_d != tgt_s);
        led_d   = (pwm_cnt < level_q) ? LED_ON : LED_OFF;
    end

    // Level and LED pin registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            level_q <= {PWM_BITS{1'b0}};
            led_q   <= LED_OFF;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_bit = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
// Output stage between the rotating pattern register and the LED pins.
// Each LED fades toward its target brightness, rendered by a shared PWM.
//   sys_clk : system clock
//   sys_rst : asynchronous active-high reset
//   io      : slave side of led_fade_pwm_if (pattern_i in, led/busy out)
// Holds the step prescaler, PWM counter, pattern register and busy flag;
// per-channel ramp and compare live in led_fade_chan.
// ---------------------------------------------------------------------------
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N_LED     = LED_N,
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int STEP_DIV  = STEP_DIV_DEF,
    parameter int UP_STEP   = UP_STEP_DEF,
    parameter int DOWN_STEP = DOWN_STEP_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    led_fade_pwm_if.slave  io
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
    // PWM period is FS cycles, so the counter wraps after FS-1.
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2**PWM_BITS) - 2);

    logic [DIV_W-1:0]    div_cnt_q;
    logic [DIV_W-1:0]    div_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [N_LED-1:0]    pat_q;
    logic [N_LED-1:0]    pat_d;
    logic                busy_q;
    logic                busy_d;
    logic                step_tick_s;
    logic [N_LED-1:0]    led_s;
    logic [N_LED-1:0]    ch_busy_s;

    // Free-running prescaler and PWM counter, pattern capture, busy update.
    always_comb begin
        step_tick_s = (div_cnt_q == DIV_LAST);

        if (step_tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = {PWM_BITS{1'b0}};
        end else begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end

        pat_d = io.pattern_i;

        // busy only moves with the levels, so pattern glitches between
        // ticks never show up on it.
        if (step_tick_s) begin
            busy_d = |ch_busy_s;
        end else begin
            busy_d = busy_q;
        end
    end

    // Shared counters, pattern register and busy flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q <= {DIV_W{1'b0}};
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            pat_q     <= {N_LED{1'b1}};
            busy_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pat_q     <= pat_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS  (PWM_BITS),
            .UP_STEP   (UP_STEP),
            .DOWN_STEP (DOWN_STEP)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .step_tick (step_tick_s),
            .pat_bit   (pat_q[i]),
            .pwm_cnt   (pwm_cnt_q),
            .led_bit   (led_s[i]),
            .ch_busy   (ch_busy_s[i])
        );
    end

    assign io.led  = led_s;
    assign io.busy = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm. Main instance uses STEP_DIV=4,
// UP_STEP=64, DOWN_STEP=32; a second instance with STEP_DIV=300 leaves a
// level steady long enough to measure a full PWM period.
module tb_led_fade_pwm;

    localparam int DIV_FAST = 4;
    localparam int DIV_SLOW = 300;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    bit   clk_en  = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // rising edges since the last reset release

    led_fade_pwm_if #(.N_LED(6)) bus ();
    led_fade_pwm_if #(.N_LED(6)) slow_bus ();

    led_fade_pwm #(
        .N_LED(6), .PWM_BITS(8), .STEP_DIV(DIV_FAST), .UP_STEP(64), .DOWN_STEP(32)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .io      (bus)
    );

    led_fade_pwm #(
        .N_LED(6), .PWM_BITS(8), .STEP_DIV(DIV_SLOW), .UP_STEP(64), .DOWN_STEP(32)
    ) dut_slow (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .io      (slow_bus)
    );

    always begin
        #5;
        if (clk_en) sys_clk = ~sys_clk;
    end

    // One rising edge, then return at the following falling edge.
    task automatic cycle();
        @(posedge sys_clk);
        cyc = cyc + 1;
        @(negedge sys_clk);
    endtask

    // Advance until the edge just taken was a level-update tick for 'div'.
    task automatic run_to_tick(input int div);
        do begin
            cycle();
        end while ((cyc % div) != 0);
    endtask

    task automatic test_reset();
        bus.pattern_i      = 6'b111111;
        slow_bus.pattern_i = 6'b111111;
        #2 sys_rst = 1'b1;
        #2;
        checks++;
        if (bus.led !== 6'b111111) begin
            errors++; $display("FAIL reset_led_noclk got %b exp %b", bus.led, 6'b111111);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy_noclk got %b exp 0", bus.busy);
        end
        clk_en = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc = 0;
        cycle();
        checks++;
        if (bus.led !== 6'b111111 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got led=%b busy=%b exp led=111111 busy=0", bus.led, bus.busy);
        end
    endtask

    task automatic test_fade_in();
        int exp_lvl [4] = '{64, 128, 192, 255};
        bit exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int bad = 0;
        bus.pattern_i = 6'b111110;
        for (int k = 0; k < 4; k++) begin
            run_to_tick(DIV_FAST);
            checks++;
            if (dut.g_chan[0].u_chan.level_q !== 8'(exp_lvl[k])) begin
                errors++; $display("FAIL fade_in_level tick%0d got %0d exp %0d", k + 1, dut.g_chan[0].u_chan.level_q, exp_lvl[k]);
            end
            checks++;
            if (bus.busy !== exp_busy[k]) begin
                errors++; $display("FAIL fade_in_busy tick%0d got %b exp %b", k + 1, bus.busy, exp_busy[k]);
            end
        end
        run_to_tick(DIV_FAST);
        checks++;
        if (dut.g_chan[0].u_chan.level_q !== 8'd255 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL fade_in_saturate got level=%0d busy=%b exp level=255 busy=0", dut.g_chan[0].u_chan.level_q, bus.busy);
        end
        cycle();
        for (int k = 0; k < 300; k++) begin
            if (bus.led !== 6'b111110) bad++;
            cycle();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_on_led bad_cycles got %0d exp 0", bad);
        end
    endtask

    task automatic test_cross_fade();
        int exp0 [8] = '{223, 191, 159, 127, 95, 63, 31, 0};
        int exp1 [8] = '{64, 128, 192, 255, 255, 255, 255, 255};
        run_to_tick(DIV_FAST);
        bus.pattern_i = 6'b111101;
        for (int k = 0; k < 8; k++) begin
            run_to_tick(DIV_FAST);
            checks++;
            if (dut.g_chan[0].u_chan.level_q !== 8'(exp0[k]) || dut.g_chan[1].u_chan.level_q !== 8'(exp1[k])) begin
                errors++; $display("FAIL cross_fade_levels tick%0d got ch0=%0d ch1=%0d exp ch0=%0d ch1=%0d", k + 1, dut.g_chan[0].u_chan.level_q, dut.g_chan[1].u_chan.level_q, exp0[k], exp1[k]);
            end
            checks++;
            if (bus.busy !== (k < 7)) begin
                errors++; $display("FAIL cross_fade_busy tick%0d got %b exp %b", k + 1, bus.busy, (k < 7));
            end
        end
    endtask

    task automatic test_pwm_duty();
        int lows = 0;
        run_to_tick(DIV_SLOW);
        slow_bus.pattern_i = 6'b111110;
        run_to_tick(DIV_SLOW);
        checks++;
        if (dut_slow.g_chan[0].u_chan.level_q !== 8'd64) begin
            errors++; $display("FAIL duty_level_tick1 got %0d exp 64", dut_slow.g_chan[0].u_chan.level_q);
        end
        run_to_tick(DIV_SLOW);
        checks++;
        if (dut_slow.g_chan[0].u_chan.level_q !== 8'd128) begin
            errors++; $display("FAIL duty_level_tick2 got %0d exp 128", dut_slow.g_chan[0].u_chan.level_q);
        end
        slow_bus.pattern_i = 6'b111111;
        for (int k = 0; k < 255; k++) begin
            cycle();
            if (slow_bus.led[0] === 1'b0) lows++;
        end
        checks++;
        if (lows !== 128) begin
            errors++; $display("FAIL duty_128 low_cycles got %0d exp 128", lows);
        end
    endtask

    task automatic test_glitch();
        run_to_tick(DIV_FAST);
        bus.pattern_i = 6'b111001;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.pattern_i = 6'b111101;
            cycle();
            checks++;
            if (bus.busy !== 1'b0 || dut.g_chan[2].u_chan.level_q !== 8'd0) begin
                errors++; $display("FAIL glitch cyc%0d got busy=%b level2=%0d exp busy=0 level2=0", k + 1, bus.busy, dut.g_chan[2].u_chan.level_q);
            end
        end
        cycle();
        checks++;
        if (bus.led[2] !== 1'b1) begin
            errors++; $display("FAIL glitch_led2 got %b exp 1", bus.led[2]);
        end
    endtask

    task automatic test_async_reset_mid_ramp();
        run_to_tick(DIV_FAST);
        bus.pattern_i = 6'b111110;
        run_to_tick(DIV_FAST);
        run_to_tick(DIV_FAST);
        checks++;
        if (dut.g_chan[0].u_chan.level_q !== 8'd128) begin
            errors++; $display("FAIL midramp_level got %0d exp 128", dut.g_chan[0].u_chan.level_q);
        end
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (bus.led !== 6'b111111 || bus.busy !== 1'b0 || dut.g_chan[0].u_chan.level_q !== 8'd0) begin
            errors++; $display("FAIL async_reset got led=%b busy=%b level0=%0d exp led=111111 busy=0 level0=0", bus.led, bus.busy, dut.g_chan[0].u_chan.level_q);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc = 0;
        run_to_tick(DIV_FAST);
        checks++;
        if (dut.g_chan[0].u_chan.level_q !== 8'd64 || dut.g_chan[1].u_chan.level_q !== 8'd0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL restart got ch0=%0d ch1=%0d busy=%b exp ch0=64 ch1=0 busy=1", dut.g_chan[0].u_chan.level_q, dut.g_chan[1].u_chan.level_q, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_cross_fade();
        test_pwm_duty();
        test_glitch();
        test_async_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
